md_issue: RTL and testbench
===========================

MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt request; flushes E-stage MD operation
- d_valid  in  1  D-stage instruction valid
- d_mdop  in  4  D-stage MD class: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as 0
- d_rs_val  in  32  forwarded rs operand
- d_rt_val  in  32  forwarded rt operand
- mdu_busy  in  1  busy from multiply/divide unit
- mdu_hi  in  32  HI from multiply/divide unit
- mdu_lo  in  32  LO from multiply/divide unit
- start  out  1  issue strobe to multiply/divide unit
- mdu_op  out  4  operation code to multiply/divide unit
- mdu_opa  out  32  operand A
- mdu_opb  out  32  operand B
- stall_d  out  1  stall D stage, insert bubble into E
- e_mf_valid  out  1  E stage holds mfhi/mflo
- e_mf_data  out  32  mfhi/mflo result
- issue_cnt  out  16  accepted-issue counter

REQ-002 Reset is reset, synchronous, active-high; clock is clk.

Function
REQ-003 E register (e_op[3:0], e_a[31:0], e_b[31:0]) SHALL load {d_mdop, d_rs_val, d_rt_val} each cycle when d_valid=1, stall_d=0, req=0; otherwise it SHALL load the bubble {0,0,0}.
REQ-004 The block SHALL drive start=1 when e_op is in 1..6, and 0 otherwise.
REQ-005 The block SHALL drive mdu_op=e_op when e_op is in 1..6, and 0 otherwise.
REQ-006 The block SHALL drive mdu_opa=e_a and mdu_opb=e_b.
REQ-007 The block SHALL drive e_mf_valid=1 when e_op is 7 or 8.
REQ-008 e_mf_data SHALL equal mdu_hi when e_op=7, mdu_lo when e_op=8, and 0 otherwise (combinational).
REQ-009 The FSM SHALL have the states IDLE, ISSUED and WAIT.
REQ-010 The FSM SHALL move IDLE->ISSUED when e_op is in 1..4 and req=0.
REQ-011 The FSM SHALL stay in IDLE for e_op 5/6, for all other e_op values, and whenever req=1.
REQ-012 The FSM SHALL move ISSUED->WAIT unconditionally after one cycle, because the multiply/divide unit raises busy the cycle after start.
REQ-013 In WAIT the FSM SHALL return to IDLE in the first cycle that samples mdu_busy=0, and SHALL stay in WAIT otherwise.
REQ-014 md_pending SHALL be true when the state is not IDLE or e_op is in 1..4.
REQ-015 stall_d SHALL be 1 exactly when d_valid=1, d_mdop is in 1..8, and md_pending=1.
REQ-016 stall_d SHALL be 0 for non-MD instructions in every state.
REQ-017 A mthi/mtlo in E followed by mfhi/mflo in D SHALL NOT stall; the multiply/divide unit has already updated HI/LO at the edge the read enters E.
REQ-018 issue_cnt SHALL increment by 1 in each cycle where start=1 and req=0, and SHALL wrap 0xFFFF->0x0000.
REQ-019 When req=1 the block SHALL leave issue_cnt and the FSM unchanged, except that ISSUED->WAIT and WAIT->IDLE still proceed so an in-flight operation is tracked to completion.
REQ-020 When req=1 and stall_d=1 occur in the same cycle, the E register SHALL load the bubble (flush wins).

Reset
REQ-021 When reset=1 the block SHALL clear e_op, e_a, e_b and issue_cnt to 0 and set the FSM to IDLE, regardless of any other input, including in the middle of an operation.
REQ-022 After reset the outputs SHALL be start=0, mdu_op=0, mdu_opa=0, mdu_opb=0, e_mf_valid=0, e_mf_data=0, issue_cnt=0, and stall_d=0 until an MD instruction is presented.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- D: mult rs=3, rt=5 -> next cycle start=1, mdu_op=1, opa=3, opb=5, issue_cnt=1; a following mflo in D gives stall_d=1 until the cycle after mdu_busy falls, then e_mf_valid=1, e_mf_data=15.
- divu 7/2 in E with req=1 in that cycle -> FSM stays IDLE, issue_cnt unchanged, E holds the bubble next cycle, stall_d=0.
- mthi rs=0xDEADBEEF, then mfhi back-to-back -> no stall; e_mf_data=0xDEADBEEF the cycle mfhi is in E.
- div issued, reset asserted while in WAIT -> next cycle FSM IDLE, issue_cnt=0, start=0, stall_d=0 for a waiting mflo once mdu_busy=0.
- Non-MD instruction (d_mdop=0) in D while in WAIT -> stall_d=0; the E register loads it normally.
- issue_cnt preset to 0xFFFF through 65535 issues, then one mtlo -> issue_cnt=0x0000.

Source files
------------

// File: rtl/md_issue.sv
// md_issue: E-stage issue logic for the multiply/divide unit.
// Holds one E-stage MD slot, strobes operations into the MDU, tracks an
// in-flight mult/div until the unit drops busy, stalls D-stage MD
// instructions while HI/LO are not yet final, and counts accepted issues.
//
// MDU handshake: start is a single-cycle strobe asserted while E holds an
// op in 1..6 (mdu_op/mdu_opa/mdu_opb are valid in that same cycle).
// The unit accepts every strobe unconditionally and, for ops 1..4, raises
// mdu_busy from the following cycle until HI/LO are written; mthi/mtlo
// update HI/LO at the edge that ends the strobe cycle and never raise busy.
module md_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        d_valid,
  input  logic [3:0]  d_mdop,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] d_rt_val,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        start,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_opa,
  output logic [31:0] mdu_opb,
  output logic        stall_d,
  output logic        e_mf_valid,
  output logic [31:0] e_mf_data,
  output logic [15:0] issue_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  e_op_q, e_op_d;
  logic [31:0] e_a_q, e_a_d;
  logic [31:0] e_b_q, e_b_d;
  logic [15:0] cnt_q, cnt_d;

  logic e_is_muldiv;  // mult/multu/div/divu in E
  logic e_is_strobe;  // any op the MDU must see (1..6)
  logic d_is_md;      // D holds any MD-class instruction (1..8)
  logic md_pending;   // HI/LO may still change

  // Decode of the E slot and D-stage instruction class.
  always_comb begin
    e_is_muldiv = (e_op_q >= 4'd1) && (e_op_q <= 4'd4);
    e_is_strobe = (e_op_q >= 4'd1) && (e_op_q <= 4'd6);
    d_is_md     = (d_mdop >= 4'd1) && (d_mdop <= 4'd8);
    md_pending  = (state_q != IDLE) || e_is_muldiv;
  end

  // MDU interface, move-from result and D-stage stall.
  always_comb begin
    start      = e_is_strobe;
    mdu_op     = e_is_strobe ? e_op_q : 4'd0;
    mdu_opa    = e_a_q;
    mdu_opb    = e_b_q;
    e_mf_valid = (e_op_q == 4'd7) || (e_op_q == 4'd8);
    e_mf_data  = 32'd0;
    if (e_op_q == 4'd7) e_mf_data = mdu_hi;
    if (e_op_q == 4'd8) e_mf_data = mdu_lo;
    // mthi/mtlo in E do not raise md_pending: HI/LO are written at the
    // same edge a following mfhi/mflo enters E, so no stall is needed.
    stall_d    = d_valid && d_is_md && md_pending;
    issue_cnt  = cnt_q;
  end

  // Next state of the in-flight tracker; ISSUED/WAIT advance even under req
  // so an operation already handed to the MDU is followed to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (e_is_muldiv && !req) state_d = ISSUED;
      ISSUED:  state_d = WAIT;
      WAIT:    if (!mdu_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next E slot and issue counter; a flush or stall inserts a bubble.
  always_comb begin
    e_op_d = 4'd0;
    e_a_d  = 32'd0;
    e_b_d  = 32'd0;
    if (d_valid && !stall_d && !req) begin
      e_op_d = d_mdop;
      e_a_d  = d_rs_val;
      e_b_d  = d_rt_val;
    end
    cnt_d = cnt_q;
    if (e_is_strobe && !req) cnt_d = cnt_q + 16'd1;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      e_op_q  <= 4'd0;
      e_a_q   <= 32'd0;
      e_b_q   <= 32'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      e_op_q  <= e_op_d;
      e_a_q   <= e_a_d;
      e_b_q   <= e_b_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// tb_md_issue: randomized and directed bench for md_issue with a
// behavioural reference model and a per-cycle compare process.
module tb_md_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        d_valid = 1'b0;
  logic [3:0]  d_mdop = 4'd0;
  logic [31:0] d_rs_val = 32'd0;
  logic [31:0] d_rt_val = 32'd0;
  logic        mdu_busy = 1'b0;
  logic [31:0] mdu_hi = 32'd0;
  logic [31:0] mdu_lo = 32'd0;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_opa;
  logic [31:0] mdu_opb;
  logic        stall_d;
  logic        e_mf_valid;
  logic [31:0] e_mf_data;
  logic [15:0] issue_cnt;

  int n_vec = 0;
  int n_err = 0;

  md_issue dut (
    .clk(clk), .reset(reset), .req(req), .d_valid(d_valid), .d_mdop(d_mdop),
    .d_rs_val(d_rs_val), .d_rt_val(d_rt_val), .mdu_busy(mdu_busy),
    .mdu_hi(mdu_hi), .mdu_lo(mdu_lo), .start(start), .mdu_op(mdu_op),
    .mdu_opa(mdu_opa), .mdu_opb(mdu_opb), .stall_d(stall_d),
    .e_mf_valid(e_mf_valid), .e_mf_data(e_mf_data), .issue_cnt(issue_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // E slot contents, issue count, and whether a mult/div handed to the
  // MDU is still outstanding (m_fresh: handed over in the last cycle, so
  // the unit's busy flag is not yet meaningful).
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic [15:0] m_cnt = 16'd0;
  bit          m_outstanding = 1'b0;
  bit          m_fresh = 1'b0;
  bit          m_valid = 1'b0;

  function automatic bit is_muldiv(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic bit is_strobe(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd6);
  endfunction

  function automatic bit m_stall();
    bit hilo_unsettled;
    hilo_unsettled = m_outstanding || is_muldiv(m_op);
    return d_valid && (d_mdop >= 4'd1) && (d_mdop <= 4'd8) && hilo_unsettled;
  endfunction

  always @(posedge clk) begin
    bit st;
    st = m_stall();
    if (reset) begin
      m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_cnt = 16'd0;
      m_outstanding = 1'b0; m_fresh = 1'b0; m_valid = 1'b1;
    end else begin
      if (m_outstanding) begin
        if (m_fresh) m_fresh = 1'b0;
        else if (!mdu_busy) m_outstanding = 1'b0;
      end else if (is_muldiv(m_op) && !req) begin
        m_outstanding = 1'b1;
        m_fresh = 1'b1;
      end
      if (is_strobe(m_op) && !req) m_cnt = m_cnt + 16'd1;
      if (d_valid && !st && !req) begin
        m_op = d_mdop; m_a = d_rs_val; m_b = d_rt_val;
      end else begin
        m_op = 4'd0; m_a = 32'd0; m_b = 32'd0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // compare process: every cycle once the model has seen reset
  always @(negedge clk) begin
    if (m_valid) begin
      logic [31:0] exp_mf;
      exp_mf = 32'd0;
      if (m_op == 4'd7) exp_mf = mdu_hi;
      if (m_op == 4'd8) exp_mf = mdu_lo;
      chk("start", {31'd0, start}, {31'd0, is_strobe(m_op)});
      chk("mdu_op", {28'd0, mdu_op}, is_strobe(m_op) ? {28'd0, m_op} : 32'd0);
      chk("mdu_opa", mdu_opa, m_a);
      chk("mdu_opb", mdu_opb, m_b);
      chk("e_mf_valid", {31'd0, e_mf_valid}, {31'd0, (m_op == 4'd7) || (m_op == 4'd8)});
      chk("e_mf_data", e_mf_data, exp_mf);
      chk("issue_cnt", {16'd0, issue_cnt}, {16'd0, m_cnt});
      chk("stall_d", {31'd0, stall_d}, {31'd0, m_stall()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    d_valid = v; d_mdop = op; d_rs_val = rs; d_rt_val = rt;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 1'b0; mdu_busy = 1'b0;
    set_d(1'b0, 4'd0, 32'd0, 32'd0);
    tick(); tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] cnt_snap;
    int busy_left;
    bit fire;
    busy_left = 0;

    do_reset();
    #1;
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_mdu_op", {28'd0, mdu_op}, 32'd0);
    chk("rst_opa", mdu_opa, 32'd0);
    chk("rst_opb", mdu_opb, 32'd0);
    chk("rst_mf_valid", {31'd0, e_mf_valid}, 32'd0);
    chk("rst_mf_data", e_mf_data, 32'd0);
    chk("rst_cnt", {16'd0, issue_cnt}, 32'd0);
    chk("rst_stall", {31'd0, stall_d}, 32'd0);

    // mult 3*5, then mflo waits for the unit
    set_d(1'b1, 4'd1, 32'd3, 32'd5);
    tick();
    set_d(1'b1, 4'd8, 32'd0, 32'd0);
    mdu_lo = 32'd15;
    #1;
    chk("s1_start", {31'd0, start}, 32'd1);
    chk("s1_op", {28'd0, mdu_op}, 32'd1);
    chk("s1_opa", mdu_opa, 32'd3);
    chk("s1_opb", mdu_opb, 32'd5);
    chk("s1_stall0", {31'd0, stall_d}, 32'd1);
    tick(); mdu_busy = 1'b1; #1;
    chk("s1_cnt", {16'd0, issue_cnt}, 32'd1);
    chk("s1_stall1", {31'd0, stall_d}, 32'd1);
    tick(); tick(); mdu_busy = 1'b0; #1;
    chk("s1_stall_fall", {31'd0, stall_d}, 32'd1);
    tick(); #1;
    chk("s1_stall_clear", {31'd0, stall_d}, 32'd0);
    tick(); set_d(1'b0, 4'd0, 32'd0, 32'd0); #1;
    chk("s1_mf_valid", {31'd0, e_mf_valid}, 32'd1);
    chk("s1_mf_data", e_mf_data, 32'd15);
    tick();

    // divu 7/2 flushed by req in its E cycle
    set_d(1'b1, 4'd4, 32'd7, 32'd2);
    tick();
    set_d(1'b0, 4'd0, 32'd0, 32'd0);
    req = 1'b1;
    cnt_snap = 16'd1;
    #1;
    chk("s2_start", {31'd0, start}, 32'd1);
    tick(); req = 1'b0;
    set_d(1'b1, 4'd8, 32'd0, 32'd0); #1;
    chk("s2_cnt", {16'd0, issue_cnt}, {16'd0, cnt_snap});
    chk("s2_bubble_op", {28'd0, mdu_op}, 32'd0);
    chk("s2_stall", {31'd0, stall_d}, 32'd0);
    tick(); set_d(1'b0, 4'd0, 32'd0, 32'd0); tick();

    // mthi then mfhi back-to-back
    set_d(1'b1, 4'd5, 32'hDEADBEEF, 32'd0);
    tick();
    set_d(1'b1, 4'd7, 32'd0, 32'd0);
    mdu_hi = 32'hDEADBEEF;
    #1;
    chk("s3_stall", {31'd0, stall_d}, 32'd0);
    chk("s3_op", {28'd0, mdu_op}, 32'd5);
    chk("s3_opa", mdu_opa, 32'hDEADBEEF);
    tick(); set_d(1'b0, 4'd0, 32'd0, 32'd0); #1;
    chk("s3_mf_valid", {31'd0, e_mf_valid}, 32'd1);
    chk("s3_mf_data", e_mf_data, 32'hDEADBEEF);
    tick();

    // div in WAIT, then reset
    set_d(1'b1, 4'd3, 32'd100, 32'd7);
    tick(); set_d(1'b0, 4'd0, 32'd0, 32'd0);
    tick(); mdu_busy = 1'b1;
    tick();
    set_d(1'b1, 4'd8, 32'd0, 32'd0); #1;
    chk("s4_stall_wait", {31'd0, stall_d}, 32'd1);
    reset = 1'b1;
    tick(); reset = 1'b0; mdu_busy = 1'b0; #1;
    chk("s4_start", {31'd0, start}, 32'd0);
    chk("s4_cnt", {16'd0, issue_cnt}, 32'd0);
    chk("s4_stall", {31'd0, stall_d}, 32'd0);
    tick(); set_d(1'b0, 4'd0, 32'd0, 32'd0); tick();

    // non-MD instruction while in WAIT
    set_d(1'b1, 4'd2, 32'd9, 32'd9);
    tick(); set_d(1'b0, 4'd0, 32'd0, 32'd0);
    tick(); mdu_busy = 1'b1;
    tick();
    set_d(1'b1, 4'd11, 32'h1234, 32'h5678); #1;
    chk("s5_stall_op11", {31'd0, stall_d}, 32'd0);
    set_d(1'b1, 4'd0, 32'h1234, 32'h5678); #1;
    chk("s5_stall_op0", {31'd0, stall_d}, 32'd0);
    tick(); set_d(1'b1, 4'd8, 32'd0, 32'd0); #1;
    chk("s5_opa", mdu_opa, 32'h1234);
    chk("s5_opb", mdu_opb, 32'h5678);
    chk("s5_start", {31'd0, start}, 32'd0);
    chk("s5_stall_mf", {31'd0, stall_d}, 32'd1);
    set_d(1'b0, 4'd0, 32'd0, 32'd0); mdu_busy = 1'b0;
    tick(); tick();

    // randomized traffic with a simple MDU busy emulation
    for (int i = 0; i < 3000; i++) begin
      fire = start && (mdu_op >= 4'd1) && (mdu_op <= 4'd4) && !req && !reset;
      tick();
      if (busy_left > 0) busy_left--;
      if (fire) busy_left = $urandom_range(1, 6);
      mdu_busy = (busy_left != 0);
      reset = ($urandom_range(0, 199) == 0);
      req = ($urandom_range(0, 7) == 0);
      set_d($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, $urandom);
      mdu_hi = $urandom;
      mdu_lo = $urandom;
    end
    do_reset();

    // issue counter wrap: 65535 mthi issues, then one mtlo
    set_d(1'b1, 4'd5, 32'd1, 32'd0);
    tick();
    for (int i = 0; i < 65535; i++) begin
      if (i == 65534) d_mdop = 4'd6;
      tick();
    end
    set_d(1'b0, 4'd0, 32'd0, 32'd0); #1;
    chk("s6_cnt_max", {16'd0, issue_cnt}, 32'h0000FFFF);
    chk("s6_mtlo_op", {28'd0, mdu_op}, 32'd6);
    tick(); #1;
    chk("s6_cnt_wrap", {16'd0, issue_cnt}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
